seq_multiplier: RTL
===================

// Module: seq_multiplier
//
// PURPOSE
//   Unsigned shift-and-add sequential multiplier. Computes the product one
//   partial product per clock and feeds the datapath result registers.
//   product connects to a register's in port; done connects to its load port.
//   The block and its downstream registers share clk and clear.
//
// PARAMETERS
//   WIDTH   8   operand width in bits; product is 2*WIDTH bits; WIDTH >= 2
//
// PORTS
//   clk           input   1          rising-edge clock
//   clear         input   1          asynchronous, active-high reset
//   start         input   1          request a multiply; sampled only in IDLE
//   multiplicand  input   WIDTH      operand A (unsigned), captured on accept
//   multiplier    input   WIDTH      operand B (unsigned), captured on accept
//   busy          output  1          high while state != IDLE
//   done          output  1          1-cycle pulse: product valid (drives load)
//   product       output  2*WIDTH    A*B, held until the next completion
//
// BEHAVIOUR
//   Reset
//   - clear=1 forces, without waiting for clk:
//     - state=IDLE; busy=0; done=0; product=0.
//     - All internal registers (operand copies, accumulator, counter) = 0.
//   - clear asserted mid-operation aborts that operation; no done pulse follows.
//   - On the first edge after clear drops, the block samples start normally.
//   FSM states: IDLE -> RUN -> DONE -> IDLE
//   - IDLE: on an edge with start=1:
//     - capture A into mcand_q and B into mplier_q;
//     - acc <= 0; count <= 0; go to RUN.
//     - start=0 keeps the block in IDLE.
//   - RUN: each edge performs one iteration:
//     - acc is a 2*WIDTH+1-bit accumulator (upper half carries 1 extra bit).
//     - If mplier_q[0]=1, add mcand_q to the upper WIDTH+1 bits of acc.
//     - Shift {acc, mplier_q} right by 1 as one logical register.
//     - count <= count+1.
//     - On the iteration where count==WIDTH-1: go to DONE and register
//       product <= final acc[2*WIDTH-1:0].
//   - DONE: done=1 for exactly this one cycle; next edge -> IDLE.
//   Handshake and outputs
//   - start is ignored in RUN and DONE; there is no queuing.
//   - start held high continuously gives back-to-back operations, each
//     separated by the IDLE cycle.
//   - done and busy decode directly from the state register (glitch-free).
//   - product changes only on the edge that enters DONE, so it is stable
//     while done=1 and afterwards.
//   Timing
//   - If start is sampled at edge N, done is high in the cycle after edge
//     N+WIDTH, and busy is high from edge N until edge N+WIDTH+1.
//   - Throughput: one result per WIDTH+2 cycles.
//   Arithmetic
//   - Unsigned only. The 2*WIDTH-bit result is exact, with no overflow:
//     (2^W-1)^2 < 2^(2W).
//   - The extra accumulator bit absorbs the carry of each add.
//   - Operand changes after acceptance do not affect the running result.
//
// TESTING
//   1. Reset, then start=1 for one cycle with A=13, B=11 (WIDTH=8):
//      busy rises next cycle; done pulses 8 edges later; product=143.
//      product stays 143 afterwards.
//   2. A=255, B=255 -> product=65025 (16'hFE01). Checks the carry bit.
//      A=0, B=200 -> 0. A=1, B=255 -> 255.
//   3. Start A=6, B=7. Two cycles later pulse start with A=9, B=9:
//      the second start is ignored; done pulses once; product=42.
//   4. Start A=100, B=50. Assert clear asynchronously after 3 RUN cycles:
//      busy=0, done=0, product=0 immediately; no done pulse occurs.
//      A fresh start with A=3, B=5 gives 15.
//   5. Hold start=1 for 40 cycles with A=12, B=12:
//      done pulses every WIDTH+2=10 cycles; every result = 144.
//   6. Random: 1000 random A/B pairs with WIDTH=8 and WIDTH=4.
//      Compare product against a reference multiply at each done.
//      Assert done never lasts more than 1 cycle.

Source files
------------

// File: rtl/seq_multiplier.sv
// Unsigned shift-and-add sequential multiplier.
// One partial product is accumulated per clock; the result is registered
// into product on entry to DONE and held until the next completion.
//
// Handshake: start is a request that is accepted only on an edge where the
// block is IDLE (busy=0); while busy=1 start is ignored and nothing is
// queued. done is a one-cycle valid strobe for product, intended to drive
// the load port of a downstream register; there is no back-pressure.
module seq_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 clear,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic [1:0]           state_dbg_o
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    // Upper WIDTH+1 bits hold the running sum plus a carry bit for each add.
    logic [2*WIDTH:0]     acc_q, acc_d;
    logic [CW-1:0]        count_q, count_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic [WIDTH:0]       addend;
    logic [WIDTH:0]       sum_upper;

    // Next-state and datapath: one iteration of add-then-shift per RUN cycle.
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        count_d   = count_q;
        product_d = product_q;
        addend    = mplier_q[0] ? {1'b0, mcand_q} : '0;
        sum_upper = acc_q[2*WIDTH:WIDTH] + addend;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d  = multiplicand;
                    mplier_d = multiplier;
                    acc_d    = '0;
                    count_d  = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                // {acc, mplier} shifts right as one register after the add.
                acc_d    = {1'b0, sum_upper, acc_q[WIDTH-1:1]};
                mplier_d = {acc_q[0], mplier_q[WIDTH-1:1]};
                count_d  = count_q + CW'(1);
                if (count_q == LAST) begin
                    product_d = acc_d[2*WIDTH-1:0];
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; clear aborts any operation in flight.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q   <= S_IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            count_q   <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            count_q   <= count_d;
            product_q <= product_d;
        end
    end

    // Status decodes straight from the state register so they never glitch.
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign product     = product_q;
    assign state_dbg_o = state_q;

endmodule
